// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction memory loader
package imem_pkg;
  localparam int WORD_W         = 72;
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - byte-to-word shift register, first byte lands in the MSBs
module imem_word_packer #(
  parameter int WORD_W = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);
  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = $clog2(BPW + 1);

  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  assign word_next = (word_q << 8) | WORD_W'(byte_in);
  // Asserted in the same cycle the word's last byte is being accepted.
  assign word_full = shift_en && (cnt_q == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
      cnt_q  <= word_full ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader into instruction memory words
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int WORD_W = imem_pkg::WORD_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import imem_pkg::*;

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_in;
  logic [ADDR_W-1:0]  word_cnt_q;
  logic [WORD_W-1:0]  word_next;
  logic               word_full;
  logic               xfer;
  logic               session_start;
  logic               last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  assign xfer          = in_valid && in_ready;
  assign len_in        = {len_hi_q, in_data};
  assign session_start = (state_d == ST_LEN_HI) && (state_q != ST_LEN_HI);
  // mem_addr holds k during WRITE, so it doubles as the last-word comparator input.
  assign last_word     = (LEN_W'(mem_addr) == len_q - LEN_W'(1));

  imem_word_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (session_start),
    .shift_en  ((state_q == ST_DATA) && xfer),
    .byte_in   (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (len_in == '0)                     state_d = ST_DONE;
          else if (len_in > LEN_W'(DEPTH))      state_d = ST_ERR;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = last_word ? ST_CHK : ST_DATA;
`else
        state_d = last_word ? ST_DONE : ST_DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_d = ST_LEN_HI;
      end
      ST_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_d = ST_LEN_HI;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (session_start) begin
        len_q      <= '0;
        word_cnt_q <= '0;
      end
      if (state_q == ST_LEN_HI && xfer) len_hi_q <= in_data;
      if (state_q == ST_LEN_LO && xfer) len_q    <= len_in;
      if (word_full) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_cnt_q;
        mem_wdata <= word_next;
      end
      if (state_q == ST_WRITE) word_cnt_q <= word_cnt_q + ADDR_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset || session_start)         csum_q <= '0;
    else if (state_q == ST_DATA && xfer) csum_q <= csum_q ^ in_data;
  end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader (cycle table plus multi-cycle sequences)
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error;
  logic [9:0]  mem_addr;
  logic [71:0] mem_wdata;

  int total = 0;
  int bad   = 0;
  int ovl_ready = 0;
  int ovl_busy  = 0;
  logic [81:0] wr_q[$];

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [71:0] wd;
    logic        bsy;
    logic        dn;
    logic        er;
  } vec_t;
  vec_t vecs[$];

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_we && in_ready) ovl_ready++;
    if (busy && (done || error)) ovl_busy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input logic [7:0] d, input logic rdy,
                     input logic we, input logic [71:0] wd, input logic bsy, input logic dn,
                     input logic er);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d; v.rdy = rdy; v.we = we; v.addr = 10'd0; v.wd = wd;
    v.bsy = bsy; v.dn = dn; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit ok = 0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %0h not accepted within 100 cycles", b);
    end
  endtask

  task automatic start_session(input logic [15:0] n);
    start = 1'b1;
    tick();
    start = 1'b0;
    send(n[15:8], 0);
    send(n[7:0], 0);
  endtask

  task automatic wait_end();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_end_timeout: busy=%0d after 100 cycles", busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"},    mem_we, 0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    int base;
    logic [7:0] csum;
    logic [71:0] exp_w[3];

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // test 1: cycle-accurate table, N=1, bytes 01..09
    add(1, 0, 8'h00, 0, 0, 72'h0, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 72'h0, 1, 0, 0);
    add(0, 1, 8'h01, 1, 0, 72'h0, 1, 0, 0);
    for (int b = 1; b <= 9; b++) add(0, 1, 8'(b), 1, 0, 72'h0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 72'h010203040506070809, 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(0, 1, 8'h01, 1, 0, 72'h0, 1, 0, 0);
`endif
    add(0, 0, 8'h00, 0, 0, 72'h0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 72'h0, 0, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; in_valid = vecs[i].vl; in_data = vecs[i].d;
      check($sformatf("t1_ready[%0d]", i), in_ready, vecs[i].rdy);
      check($sformatf("t1_we[%0d]", i),    mem_we,   vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("t1_addr[%0d]", i),  mem_addr,  vecs[i].addr);
        check($sformatf("t1_wdata[%0d]", i), mem_wdata, vecs[i].wd);
      end
      check($sformatf("t1_busy[%0d]", i),  busy,  vecs[i].bsy);
      check($sformatf("t1_done[%0d]", i),  done,  vecs[i].dn);
      check($sformatf("t1_error[%0d]", i), error, vecs[i].er);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;

    // test 2: N=3, gapped stream
    base = wr_q.size();
    exp_w[0] = 72'h101112131415161718;
    exp_w[1] = 72'h191A1B1C1D1E1F2021;
    exp_w[2] = 72'h22232425262728292A;
    csum = 8'h00;
    start_session(16'd3);
    for (int i = 0; i < 27; i++) begin
      send(8'(8'h10 + i), 1);
      csum ^= 8'(8'h10 + i);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum, 0);
`endif
    wait_end();
    check("t2_count", wr_q.size() - base, 3);
    for (int k = 0; k < 3 && base + k < wr_q.size(); k++) begin
      check($sformatf("t2_addr%0d", k),  wr_q[base+k][81:72], k);
      check($sformatf("t2_wdata%0d", k), wr_q[base+k][71:0], exp_w[k]);
    end
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_ready_in_write", ovl_ready, 0);

    // test 3: oversize length
    base = wr_q.size();
    start_session(16'h0401);
    check("t3_error", error, 1);
    check("t3_done", done, 0);
    check("t3_ready", in_ready, 0);
    check("t3_busy", busy, 0);
    check("t3_nowrite", wr_q.size() - base, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_err_cleared", error, 0);
    check("t3_busy_again", busy, 1);

    // test 4: zero length, then start while busy is ignored
    send(8'h00, 0);
    send(8'h00, 0);
    check("t4_done_zero", done, 1);
    check("t4_busy_zero", busy, 0);
    check("t4_nowrite", wr_q.size() - base, 0);
    start_session(16'd1);
    for (int i = 0; i < 3; i++) send(8'(8'hA1 + i), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 3; i < 9; i++) send(8'(8'hA1 + i), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'hA1 ^ 8'hA2 ^ 8'hA3 ^ 8'hA4 ^ 8'hA5 ^ 8'hA6 ^ 8'hA7 ^ 8'hA8 ^ 8'hA9, 0);
`endif
    wait_end();
    check("t4_done", done, 1);
    check("t4_count", wr_q.size() - base, 1);
    if (wr_q.size() > base) begin
      check("t4_addr", wr_q[base][81:72], 0);
      check("t4_wdata", wr_q[base][71:0], 72'hA1A2A3A4A5A6A7A8A9);
    end

    // test 5: reset mid-word, then clean reload
    base = wr_q.size();
    start_session(16'd2);
    for (int i = 0; i < 9; i++) send(8'(8'h21 + i), 0);
    for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 0);
    reset = 1'b0;
    tick();
    check_reset_outputs("t5_rst");
    check("t5_one_write", wr_q.size() - base, 1);
    reset = 1'b1;
    tick();
    start_session(16'd1);
    for (int i = 0; i < 9; i++) send(8'(8'h41 + i), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h41 ^ 8'h42 ^ 8'h43 ^ 8'h44 ^ 8'h45 ^ 8'h46 ^ 8'h47 ^ 8'h48 ^ 8'h49, 0);
`endif
    wait_end();
    check("t5_done", done, 1);
    check("t5_count", wr_q.size() - base, 2);
    if (wr_q.size() > base + 1) begin
      check("t5_addr", wr_q[base+1][81:72], 0);
      check("t5_wdata", wr_q[base+1][71:0], 72'h414243444546474849);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // test 6: bad checksum keeps the write but flags error
    base = wr_q.size();
    start_session(16'd1);
    for (int i = 1; i <= 9; i++) send(8'(i), 0);
    send(8'h00, 0);
    wait_end();
    check("t6_error", error, 1);
    check("t6_done", done, 0);
    check("t6_count", wr_q.size() - base, 1);
    if (wr_q.size() > base) check("t6_wdata", wr_q[base][71:0], 72'h010203040506070809);
`endif

    check("busy_with_done_or_error", ovl_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
